// File: rtl/urv_exec_divider_pkg.sv
// Shared definitions for the execute-stage divider.
// Contents:
//   FUNCT3_DIV/DIVU/REM/REMU - RV32M funct3 codes handled by the divider
//   fun_is_signed()          - DIV/REM (fun[0]==0) operate on signed operands
//   fun_is_rem()             - REM/REMU (fun[1]==1) return the remainder
package urv_exec_divider_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    function automatic logic fun_is_signed(input logic [2:0] fun);
        return ~fun[0];
    endfunction

    function automatic logic fun_is_rem(input logic [2:0] fun);
        return fun[1];
    endfunction

endpackage

// File: rtl/urv_div_step.sv
// One combinational radix-2 restoring division step.
// Ports:
//   rem_i - partial remainder entering the step (always < div_i when div_i != 0)
//   bit_i - next dividend bit shifted into the partial remainder
//   div_i - divisor magnitude
//   rem_o - partial remainder leaving the step
//   q_o   - quotient bit produced by the step
module urv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, div_i});
        // When q_o is set the difference is below div_i, so it fits in XLEN bits.
        rem_o   = q_o ? (shifted[XLEN-1:0] - div_i) : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/urv_exec_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the execute stage.
// Ports:
//   clk_i, rst_i       - clock, synchronous active-low reset
//   x_stall_i          - global execute stall (includes our own request)
//   x_kill_i           - flush of the instruction in execute
//   x_stall_req_o      - stall request while the divide is in progress
//   d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i - instruction in execute
//   x_rd_o             - registered result (quotient or remainder)
//   x_busy_o           - FSM is not IDLE
module urv_exec_divider
    import urv_exec_divider_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_OUT      = 1,
    parameter int RESULT_CACHE   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    output logic            x_stall_req_o,
    input  logic            d_valid_i,
    input  logic            d_is_divide_i,
    input  logic [2:0]      d_fun_i,
    input  logic [XLEN-1:0] d_rs1_i,
    input  logic [XLEN-1:0] d_rs2_i,
    output logic [XLEN-1:0] x_rd_o,
    output logic            x_busy_o
);

    localparam int N_ITER = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);
    localparam logic [XLEN-1:0]  MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;        // partial remainder
    logic [XLEN-1:0]   quo_q, quo_d;        // dividend bits out, quotient bits in
    logic [XLEN-1:0]   dvsr_q, dvsr_d;      // divisor magnitude
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic              signed_q, signed_d;
    logic              sel_rem_q, sel_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic              c_vld_q, c_vld_d;
    logic [XLEN-1:0]   c_rs1_q, c_rs1_d;
    logic [XLEN-1:0]   c_rs2_q, c_rs2_d;
    logic              c_signed_q, c_signed_d;
    logic [XLEN-1:0]   c_quo_q, c_quo_d;
    logic [XLEN-1:0]   c_rem_q, c_rem_d;

    // Operand decode for the start cycle
    logic                   start, in_signed, in_rem, a_neg, b_neg;
    logic                   div_zero, ovf, special, hit;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [XLEN-1:0]        abs_a, abs_b, early_quo, early_rem;

    always_comb begin
        rs1_s     = d_rs1_i;
        rs2_s     = d_rs2_i;
        in_signed = fun_is_signed(d_fun_i);
        in_rem    = fun_is_rem(d_fun_i);
        a_neg     = in_signed & rs1_s[XLEN-1];
        b_neg     = in_signed & rs2_s[XLEN-1];
        abs_a     = a_neg ? -rs1_s : rs1_s;
        abs_b     = b_neg ? -rs2_s : rs2_s;
        div_zero  = (d_rs2_i == '0);
        ovf       = in_signed & (d_rs1_i == MIN_VAL) & (d_rs2_i == '1);
        special   = (EARLY_OUT != 0) & (div_zero | ovf);
        early_quo = div_zero ? '1 : MIN_VAL;
        early_rem = div_zero ? d_rs1_i : '0;
        hit       = (RESULT_CACHE != 0) & c_vld_q & (c_rs1_q == d_rs1_i) &
                    (c_rs2_q == d_rs2_i) & (c_signed_q == in_signed);
        start     = (state_q == ST_IDLE) & d_valid_i & d_is_divide_i &
                    d_fun_i[2] & ~x_kill_i;
    end

    // Step chain: BITS_PER_CYCLE restoring steps per BUSY cycle
    logic [XLEN-1:0]           chain_rem [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] step_q;
    logic [XLEN-1:0]           quo_step, quo_fin, rem_fin;

    assign chain_rem[0] = rem_q;

    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        urv_div_step #(.XLEN(XLEN)) u_step (
            .rem_i (chain_rem[gi]),
            .bit_i (quo_q[XLEN-1-gi]),
            .div_i (dvsr_q),
            .rem_o (chain_rem[gi+1]),
            .q_o   (step_q[BITS_PER_CYCLE-1-gi])
        );
    end

    always_comb begin
        quo_step = (quo_q << BITS_PER_CYCLE) | XLEN'(step_q);
        quo_fin  = neg_quo_q ? -quo_step : quo_step;
        rem_fin  = neg_rem_q ? -chain_rem[BITS_PER_CYCLE] : chain_rem[BITS_PER_CYCLE];
    end

    logic stall_req;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        signed_d   = signed_q;
        sel_rem_d  = sel_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        rd_d       = rd_q;
        c_vld_d    = c_vld_q;
        c_rs1_d    = c_rs1_q;
        c_rs2_d    = c_rs2_q;
        c_signed_d = c_signed_q;
        c_quo_d    = c_quo_q;
        c_rem_d    = c_rem_q;
        stall_req  = 1'b0;

        if (x_kill_i) begin
            // A killed op leaves the result and cache untouched.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        stall_req = 1'b1;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = abs_a;
                        dvsr_d    = abs_b;
                        rs1_d     = d_rs1_i;
                        rs2_d     = d_rs2_i;
                        signed_d  = in_signed;
                        sel_rem_d = in_rem;
                        // Division by zero keeps the all-ones quotient unsigned-looking.
                        neg_quo_d = (a_neg ^ b_neg) & ~div_zero;
                        neg_rem_d = a_neg;
                        if (hit) begin
                            state_d = ST_DONE;
                            rd_d    = in_rem ? c_rem_q : c_quo_q;
                        end else if (special) begin
                            state_d    = ST_DONE;
                            rd_d       = in_rem ? early_rem : early_quo;
                            c_vld_d    = (RESULT_CACHE != 0);
                            c_rs1_d    = d_rs1_i;
                            c_rs2_d    = d_rs2_i;
                            c_signed_d = in_signed;
                            c_quo_d    = early_quo;
                            c_rem_d    = early_rem;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    stall_req = 1'b1;
                    rem_d     = chain_rem[BITS_PER_CYCLE];
                    quo_d     = quo_step;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d    = ST_DONE;
                        rd_d       = sel_rem_q ? rem_fin : quo_fin;
                        c_vld_d    = (RESULT_CACHE != 0);
                        c_rs1_d    = rs1_q;
                        c_rs2_d    = rs2_q;
                        c_signed_d = signed_q;
                        c_quo_d    = quo_fin;
                        c_rem_d    = rem_fin;
                    end
                end
                ST_DONE: begin
                    // Stay here while someone else stalls; no restart from DONE.
                    if (!x_stall_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            c_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            c_vld_q <= c_vld_d;
        end
        cnt_q      <= cnt_d;
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        dvsr_q     <= dvsr_d;
        rs1_q      <= rs1_d;
        rs2_q      <= rs2_d;
        signed_q   <= signed_d;
        sel_rem_q  <= sel_rem_d;
        neg_quo_q  <= neg_quo_d;
        neg_rem_q  <= neg_rem_d;
        c_rs1_q    <= c_rs1_d;
        c_rs2_q    <= c_rs2_d;
        c_signed_q <= c_signed_d;
        c_quo_q    <= c_quo_d;
        c_rem_q    <= c_rem_d;
    end

    assign x_stall_req_o = stall_req & rst_i;
    assign x_rd_o        = rd_q;
    assign x_busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_urv_exec_divider.sv
// Self-checking bench for urv_exec_divider (XLEN=32, one quotient bit per cycle).
module tb_urv_exec_divider;
    import urv_exec_divider_pkg::*;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        x_stall_req_o;
    logic        d_valid_i;
    logic        d_is_divide_i;
    logic [2:0]  d_fun_i;
    logic [31:0] d_rs1_i;
    logic [31:0] d_rs2_i;
    logic [31:0] x_rd_o;
    logic        x_busy_o;
    logic        ext_stall;

    always #5 clk_i = ~clk_i;
    assign x_stall_i = x_stall_req_o | ext_stall;

    urv_exec_divider #(
        .XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1), .RESULT_CACHE(1)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .x_stall_i     (x_stall_i),
        .x_kill_i      (x_kill_i),
        .x_stall_req_o (x_stall_req_o),
        .d_valid_i     (d_valid_i),
        .d_is_divide_i (d_is_divide_i),
        .d_fun_i       (d_fun_i),
        .d_rs1_i       (d_rs1_i),
        .d_rs2_i       (d_rs2_i),
        .x_rd_o        (x_rd_o),
        .x_busy_o      (x_busy_o)
    );

    typedef struct {
        logic [31:0] rd;
        int          stalls;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] last_rd  = '0;

    // Bench-side view of the result cache
    bit          bc_vld = 1'b0;
    logic [31:0] bc_a, bc_b;
    bit          bc_signed;

    function automatic logic [31:0] ref_result(input logic [2:0] fun, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!fun[0] && a == MIN32 && b == 32'hFFFF_FFFF) begin
            q = MIN32;
            r = 32'd0;
        end else if (!fun[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return fun[1] ? r : q;
    endfunction

    function automatic int ref_stalls(input logic [2:0] fun, input logic [31:0] a,
                                      input logic [31:0] b);
        bit special, hit;
        special = (b == 32'd0) || (!fun[0] && a == MIN32 && b == 32'hFFFF_FFFF);
        hit     = bc_vld && bc_a == a && bc_b == b && bc_signed == !fun[0];
        return (special || hit) ? 1 : 33;
    endfunction

    task automatic drive_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        d_valid_i     = 1'b1;
        d_is_divide_i = 1'b1;
        d_fun_i       = fun;
        d_rs1_i       = a;
        d_rs2_i       = b;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after retirement.
    task automatic run_op(input string name, input logic [2:0] fun, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        exp_t e;
        int   stalls;
        bit   done;
        e.rd     = ref_result(fun, a, b);
        e.stalls = ref_stalls(fun, a, b);
        sb_q.push_back(e);
        drive_op(fun, a, b);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_i);
            if (x_stall_req_o) stalls++;
            else if (x_busy_o) done = 1'b1;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (!done) begin
            n_fails++;
            $display("FAIL %s done: no DONE within 100 cycles, stall cycles seen %0d", name, stalls);
        end else begin
            n_checks++;
            if (x_rd_o !== e.rd) begin
                n_fails++;
                $display("FAIL %s rd: got %h want %h", name, x_rd_o, e.rd);
            end
            n_checks++;
            if (stalls != e.stalls) begin
                n_fails++;
                $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, e.stalls);
            end
            bc_vld    = 1'b1;
            bc_a      = a;
            bc_b      = b;
            bc_signed = !fun[0];
            last_rd   = e.rd;
        end
        if (hold > 0) begin
            ext_stall = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk_i);
                n_checks++;
                if (x_busy_o !== 1'b1 || x_stall_req_o !== 1'b0 || x_rd_o !== e.rd) begin
                    n_fails++;
                    $display("FAIL %s hold%0d: busy=%b req=%b rd=%h want busy=1 req=0 rd=%h",
                             name, k, x_busy_o, x_stall_req_o, x_rd_o, e.rd);
                end
            end
            ext_stall = 1'b0;
        end
        @(posedge clk_i);
        #1;
        d_valid_i     = 1'b0;
        d_is_divide_i = 1'b0;
        n_checks++;
        if (x_busy_o !== 1'b0) begin
            n_fails++;
            $display("FAIL %s retire_busy: got %b want 0", name, x_busy_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive_op(FUNCT3_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (x_stall_req_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_stall_req: got %b want 0", x_stall_req_o);
        end
        n_checks++;
        if (x_busy_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_busy: got %b want 0", x_busy_o);
        end
        n_checks++;
        if (x_rd_o !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_rd: got %h want 0", x_rd_o);
        end
        d_valid_i     = 1'b0;
        d_is_divide_i = 1'b0;
        rst_i         = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_unsigned();
        run_op("divu_100_7", FUNCT3_DIVU, 32'd100, 32'd7, 0);
        run_op("remu_100_7", FUNCT3_REMU, 32'd100, 32'd7, 0);
    endtask

    task automatic test_signed();
        run_op("div_m7_2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_7_m2", FUNCT3_REM, 32'd7, 32'hFFFF_FFFE, 0);
    endtask

    task automatic test_special();
        run_op("div_5_0",      FUNCT3_DIV,  32'd5, 32'd0, 0);
        run_op("remu_5_0",     FUNCT3_REMU, 32'd5, 32'd0, 0);
        run_op("div_min_m1",   FUNCT3_DIV,  MIN32, 32'hFFFF_FFFF, 0);
        run_op("rem_min_m1",   FUNCT3_REM,  MIN32, 32'hFFFF_FFFF, 0);
        run_op("div_m9_0",     FUNCT3_DIV,  32'hFFFF_FFF7, 32'd0, 0);
    endtask

    task automatic test_back_to_back();
        run_op("div_1000_3", FUNCT3_DIV, 32'd1000, 32'd3, 0);
        run_op("rem_1000_3", FUNCT3_REM, 32'd1000, 32'd3, 0);
    endtask

    task automatic test_kill();
        drive_op(FUNCT3_DIVU, 32'd9, 32'd3);
        @(negedge clk_i);
        n_checks++;
        if (x_stall_req_o !== 1'b1) begin
            n_fails++;
            $display("FAIL kill_start_req: got %b want 1", x_stall_req_o);
        end
        repeat (10) @(posedge clk_i);
        #1;
        x_kill_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (x_stall_req_o !== 1'b0) begin
            n_fails++;
            $display("FAIL kill_req_drop: got %b want 0", x_stall_req_o);
        end
        @(posedge clk_i);
        #1;
        x_kill_i      = 1'b0;
        d_valid_i     = 1'b0;
        d_is_divide_i = 1'b0;
        n_checks++;
        if (x_busy_o !== 1'b0 || x_rd_o !== last_rd) begin
            n_fails++;
            $display("FAIL kill_idle: busy=%b rd=%h want busy=0 rd=%h", x_busy_o, x_rd_o, last_rd);
        end
        run_op("divu_9_3_after_kill", FUNCT3_DIVU, 32'd9, 32'd3, 0);
    endtask

    task automatic test_ext_stall();
        run_op("divu_ext_hold", FUNCT3_DIVU, 32'd123456, 32'd789, 3);
    endtask

    task automatic test_reset_busy();
        run_op("divu_100_7_pre", FUNCT3_DIVU, 32'd100, 32'd7, 0);
        drive_op(FUNCT3_DIVU, 32'd50, 32'd5);
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (x_busy_o !== 1'b0 || x_rd_o !== 32'd0 || x_stall_req_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid_busy: busy=%b rd=%h req=%b want 0/0/0",
                     x_busy_o, x_rd_o, x_stall_req_o);
        end
        d_valid_i     = 1'b0;
        d_is_divide_i = 1'b0;
        rst_i         = 1'b1;
        bc_vld        = 1'b0;
        last_rd       = 32'd0;
        run_op("remu_100_7_after_reset", FUNCT3_REMU, 32'd100, 32'd7, 0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  fun;
        logic [1:0]  sel;
        for (int i = 0; i < 8; i++) begin
            sel = 2'($urandom_range(0, 3));
            fun = {1'b1, sel};
            if (i % 3 != 2) begin
                a = $urandom;
                b = (i == 4) ? 32'd0 : ($urandom % 32'd5000) + 32'd1;
                if (i == 6) b = -b;
            end
            run_op("random", fun, a, b, 0);
        end
    endtask

    initial begin
        x_kill_i      = 1'b0;
        ext_stall     = 1'b0;
        d_valid_i     = 1'b0;
        d_is_divide_i = 1'b0;
        d_fun_i       = 3'b000;
        d_rs1_i       = '0;
        d_rs2_i       = '0;
        rst_i         = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_kill();
        test_ext_stall();
        test_reset_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
